sext_stream_unit: RTL

//  Streaming, parametrised width extender: accepts IN_W-bit words on a val/rdy

---
 rtl/sext_stream_unit.sv | 113 +++++++++++
 1 files changed

// File: rtl/sext_stream_unit.sv
// Streaming sign/zero width extender with a val/rdy interface on both sides.
// A primary output register (P) drives out_msg; a skid register (S) absorbs one
// word accepted while P is stalled, so in_rdy depends only on registered state.
// Optional feature: define SEXT_STREAM_UNIT_CNT_EN to count completed output
// transfers on out_count; otherwise out_count is tied to zero.
module sext_stream_unit #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [IN_W-1:0]  in_msg,
  input  logic             in_sext,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [OUT_W-1:0] out_msg,
  output logic [31:0]      out_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [OUT_W-1:0] p_msg;
  logic [OUT_W-1:0] s_msg;
  logic [OUT_W-1:0] ext_word;
  logic             in_fire;
  logic             out_fire;

  // The word is extended on entry, so both registers hold final-width data.
  generate
    if (OUT_W > IN_W) begin : g_ext
      assign ext_word = {{(OUT_W-IN_W){in_sext & in_msg[IN_W-1]}}, in_msg};
    end else begin : g_pass
      assign ext_word = in_msg;
    end
  endgenerate

  // Handshake outputs decode straight from the state register.
  assign in_rdy   = (state != TWO);
  assign out_val  = (state != EMPTY);
  assign out_msg  = p_msg;
  assign in_fire  = in_val & in_rdy;
  assign out_fire = out_val & out_rdy;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (!reset_n) state <= EMPTY;
    else          state <= state_next;
  end

  // Next-state logic on buffer occupancy.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      EMPTY: if (in_fire) state_next = ONE;
      ONE: begin
        if (in_fire && !out_fire)      state_next = TWO;
        else if (!in_fire && out_fire) state_next = EMPTY;
      end
      TWO:     if (out_fire) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // Data path: P loads the incoming word or drains S; S catches a stalled word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_msg <= '0;
      s_msg <= '0;
    end else begin
      unique case (state)
        EMPTY: if (in_fire) p_msg <= ext_word;
        ONE: begin
          if (in_fire && out_fire) p_msg <= ext_word;
          else if (in_fire)        s_msg <= ext_word;
        end
        TWO: begin
          if (out_fire) begin
            p_msg <= s_msg;
            s_msg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEXT_STREAM_UNIT_CNT_EN
  logic [31:0] xfer_count;

  // Free-running count of output transfers; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      xfer_count <= '0;
    else if (out_fire) xfer_count <= xfer_count + 32'd1;
  end

  assign out_count = xfer_count;
`else
  assign out_count = '0;
`endif

endmodule
